conv_load_scheduler: RTL and testbench

//  Sequences one convolution layer per image: accepts a byte stream (valid/ready) and writes weights+biases

---
 rtl/conv_load_scheduler_pkg.sv | 29 ++
 rtl/conv_load_scheduler_load_word_counter.sv | 36 +++
 rtl/conv_load_scheduler.sv | 158 +++++++++++++++
 tb/tb_conv_load_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_load_scheduler_pkg.sv
// rtl/conv_load_scheduler_pkg.sv - shared state encoding and layer-size helpers
package conv_load_scheduler_pkg;

  // Scheduler phases for one image
  typedef enum logic [1:0] {
    ST_LOAD_WGT = 2'd0,
    ST_LOAD_ACT = 2'd1,
    ST_CONV     = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

  // Number of outputs produced by a square valid-padding convolution
  function automatic int out_count(input int matrix_size, input int kernel_size, input int stride);
    int side;
    side = (matrix_size - kernel_size) / stride + 1;
    return side * side;
  endfunction

  // Weights followed by one bias per weight position
  function automatic int wgt_total(input int kernel_size);
    return 2 * kernel_size * kernel_size;
  endfunction

  // Full activation matrix
  function automatic int act_total(input int matrix_size);
    return matrix_size * matrix_size;
  endfunction

endpackage

// File: rtl/conv_load_scheduler_load_word_counter.sv
// rtl/conv_load_scheduler_load_word_counter.sv - up counter that clears itself on its terminal value
module load_word_counter #(
  parameter int AddrBits = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic [AddrBits-1:0] term_i,
  output logic [AddrBits-1:0] count_o,
  output logic                at_term_o
);

  logic [AddrBits-1:0] count_q;
  logic [AddrBits-1:0] count_d;

  assign at_term_o = (count_q == term_i);
  assign count_o   = count_q;

  // Increment per event; the terminal event returns to zero so the count never wraps
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = at_term_o ? '0 : count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_load_scheduler.sv
// rtl/conv_load_scheduler.sv - per-image load/convolve sequencer feeding weight and activation BRAMs
module conv_load_scheduler
  import conv_load_scheduler_pkg::*;
#(
  parameter int N          = 8,
  parameter int AddrBits   = 11,
  parameter int MatrixSize = 28,
  parameter int KernelSize = 3,
  parameter int Stride     = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                wgt_reload_i,
  output logic                wgt_we_o,
  output logic [AddrBits-1:0] wgt_addr_o,
  output logic [N-1:0]        wgt_data_o,
  output logic                act_we_o,
  output logic [AddrBits-1:0] act_addr_o,
  output logic [N-1:0]        act_data_o,
  output logic                conv_run_o,
  input  logic                conv_valid_i,
  output logic                busy_o,
  output logic                img_done_o
);

  localparam int WgtTot = wgt_total(KernelSize);
  localparam int ActTot = act_total(MatrixSize);
  localparam int OutTot = out_count(MatrixSize, KernelSize, Stride);

  localparam logic [AddrBits-1:0] WgtLast = AddrBits'(WgtTot - 1);
  localparam logic [AddrBits-1:0] ActLast = AddrBits'(ActTot - 1);
  localparam logic [AddrBits-1:0] OutLast = AddrBits'(OutTot - 1);

  // Totals must fit the counters, otherwise terminal compares would never match
  if (WgtTot > (1 << AddrBits)) begin : g_wgt_too_big
    $error("conv_load_scheduler: weight total exceeds address range");
  end
  if (ActTot > (1 << AddrBits)) begin : g_act_too_big
    $error("conv_load_scheduler: activation total exceeds address range");
  end
  if (OutTot > (1 << AddrBits)) begin : g_out_too_big
    $error("conv_load_scheduler: output total exceeds counter range");
  end

  sched_state_e state_q, state_d;
  logic         reload_flag_q, reload_flag_d;
  logic         conv_run_q, conv_run_d;
  logic         busy_q, busy_d;
  logic         img_done_q, img_done_d;

  logic                xfer;
  logic                in_wgt;
  logic                in_act;
  logic [AddrBits-1:0] word_cnt;
  logic [AddrBits-1:0] word_term;
  logic                word_at_term;
  logic                out_inc;
  logic [AddrBits-1:0] out_cnt;
  logic                out_at_term;

  assign in_wgt    = (state_q == ST_LOAD_WGT);
  assign in_act    = (state_q == ST_LOAD_ACT);
  assign s_ready_o = in_wgt | in_act;
  assign xfer      = s_valid_i & s_ready_o;
  assign word_term = in_wgt ? WgtLast : ActLast;
  assign out_inc   = conv_valid_i & (state_q == ST_CONV);

  load_word_counter #(.AddrBits(AddrBits)) u_word_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (xfer),
    .term_i    (word_term),
    .count_o   (word_cnt),
    .at_term_o (word_at_term)
  );

  load_word_counter #(.AddrBits(AddrBits)) u_out_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (out_inc),
    .term_i    (OutLast),
    .count_o   (out_cnt),
    .at_term_o (out_at_term)
  );

  // Port-A writes pass the accepted word straight through at the current word index
  always_comb begin
    wgt_we_o   = xfer & in_wgt;
    act_we_o   = xfer & in_act;
    wgt_addr_o = word_cnt;
    act_addr_o = word_cnt;
    wgt_data_o = s_data_i;
    act_data_o = s_data_i;
  end

  // Next-state, sticky reload request and registered status outputs
  always_comb begin
    state_d       = state_q;
    reload_flag_d = reload_flag_q;
    conv_run_d    = conv_run_q;
    if (wgt_reload_i && (state_q != ST_DONE)) begin
      reload_flag_d = 1'b1;
    end
    unique case (state_q)
      ST_LOAD_WGT: begin
        if (xfer && word_at_term) begin
          state_d = ST_LOAD_ACT;
        end
      end
      ST_LOAD_ACT: begin
        if (xfer && word_at_term) begin
          state_d    = ST_CONV;
          conv_run_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (out_inc && out_at_term) begin
          state_d    = ST_DONE;
          conv_run_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d       = (reload_flag_q || wgt_reload_i) ? ST_LOAD_WGT : ST_LOAD_ACT;
        reload_flag_d = 1'b0;
      end
      default: state_d = ST_LOAD_WGT;
    endcase
    // In LOAD_WGT the block only counts as busy once the first weight is taken
    busy_d     = (state_d != ST_LOAD_WGT) ||
                 ((state_q == ST_LOAD_WGT) && (xfer || busy_q));
    img_done_d = (state_d == ST_DONE);
  end

  // Scheduler FSM register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_LOAD_WGT;
      reload_flag_q <= 1'b0;
      conv_run_q    <= 1'b0;
      busy_q        <= 1'b0;
      img_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      reload_flag_q <= reload_flag_d;
      conv_run_q    <= conv_run_d;
      busy_q        <= busy_d;
      img_done_q    <= img_done_d;
    end
  end

  assign conv_run_o = conv_run_q;
  assign busy_o     = busy_q;
  assign img_done_o = img_done_q;

endmodule

// File: tb/tb_conv_load_scheduler.sv
// tb/tb_conv_load_scheduler.sv - scoreboard bench for conv_load_scheduler
module tb_conv_load_scheduler;

  localparam int WGT = 18;
  localparam int ACT = 784;
  localparam int OUT = 676;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wgt_reload;
  logic        wgt_we;
  logic [10:0] wgt_addr;
  logic [7:0]  wgt_data;
  logic        act_we;
  logic [10:0] act_addr;
  logic [7:0]  act_data;
  logic        conv_run;
  logic        conv_valid;
  logic        busy;
  logic        img_done;

  conv_load_scheduler #(
    .N(8), .AddrBits(11), .MatrixSize(28), .KernelSize(3), .Stride(1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .wgt_reload_i (wgt_reload),
    .wgt_we_o     (wgt_we),
    .wgt_addr_o   (wgt_addr),
    .wgt_data_o   (wgt_data),
    .act_we_o     (act_we),
    .act_addr_o   (act_addr),
    .act_data_o   (act_data),
    .conv_run_o   (conv_run),
    .conv_valid_i (conv_valid),
    .busy_o       (busy),
    .img_done_o   (img_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_act;
    logic [10:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, actual, required, $time);
    end
  endtask

  task automatic push_exp(input logic is_act, input int addr, input logic [7:0] data);
    exp_t e;
    e.is_act = is_act;
    e.addr   = 11'(addr);
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every port-A write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (wgt_we && act_we) chk("both_we", 32'd1, 32'd0);
      if (wgt_we || act_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {act_we, 4'd0, act_addr, 8'd0, act_data}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_target", {31'd0, act_we}, {31'd0, e.is_act});
          chk("write_addr", {21'd0, (act_we ? act_addr : wgt_addr)}, {21'd0, e.addr});
          chk("write_data", {24'd0, (act_we ? act_data : wgt_data)}, {24'd0, e.data});
        end
      end
      if (img_done) done_seen++;
    end
  end

  // Present one word, hold it until accepted, drop valid afterwards
  task automatic send_word(input logic [7:0] d, input int gap);
    bit acc;
    int n;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    s_data  = d;
    s_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_weights(input logic [7:0] base);
    for (int k = 0; k < WGT; k++) begin
      push_exp(1'b0, k, base + 8'(k));
      send_word(base + 8'(k), 0);
    end
  endtask

  // Activation stream with irregular valid gaps, optional stray conv_valid pulses
  task automatic send_acts(input int count, input logic [7:0] seed, input bit stray_conv);
    for (int k = 0; k < count; k++) begin
      if (stray_conv && (k == 10 || k == 300 || k == 500)) begin
        conv_valid = 1'b1;
        @(posedge clk); #1;
        conv_valid = 1'b0;
      end
      push_exp(1'b1, k, 8'(k * 7) ^ seed);
      send_word(8'(k * 7) ^ seed, (k % 5 == 3) ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  // Drive all convolution outputs and check the end-of-image handshake
  task automatic run_conv(input bit pulse_reload, input logic exp_busy_after);
    int n;
    n = 0;
    while (!conv_run && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!conv_run) chk("conv_run_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < OUT; i++) begin
      if (i % 97 == 5) begin
        @(posedge clk); #1;
      end
      if (i == OUT - 1) chk("img_done_early", {31'd0, img_done}, 32'd0);
      conv_valid = 1'b1;
      wgt_reload = pulse_reload && (i == 100);
      @(posedge clk); #1;
      conv_valid = 1'b0;
      wgt_reload = 1'b0;
    end
    @(negedge clk);
    chk("img_done_pulse", {31'd0, img_done}, 32'd1);
    chk("conv_run_drop", {31'd0, conv_run}, 32'd0);
    chk("ready_in_done", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("img_done_single", {31'd0, img_done}, 32'd0);
    chk("ready_after_done", {31'd0, s_ready}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, {31'd0, exp_busy_after});
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_wgt_we"}, {31'd0, wgt_we}, 32'd0);
    chk({tag, "_act_we"}, {31'd0, act_we}, 32'd0);
    chk({tag, "_addrs"}, {10'd0, wgt_addr, act_addr}, 32'd0);
    chk({tag, "_conv_run"}, {31'd0, conv_run}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_img_done"}, {31'd0, img_done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    s_data     = 8'h00;
    s_valid    = 1'b0;
    wgt_reload = 1'b0;
    conv_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Weights 0x01..0x12 back to back, then the first activation lands at act addr 0
    send_weights(8'h01);
    @(negedge clk);
    chk("busy_in_act", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    send_acts(ACT, 8'h5A, 1'b0);
    @(negedge clk);
    chk("ready_in_conv", {31'd0, s_ready}, 32'd0);
    chk("conv_run_rise", {31'd0, conv_run}, 32'd1);
    @(posedge clk); #1;
    run_conv(1'b0, 1'b1);

    // Second image reuses weights; reload requested mid-convolution
    send_acts(ACT, 8'h33, 1'b0);
    run_conv(1'b1, 1'b0);
    chk("busy_idle_wgt", {31'd0, busy}, 32'd0);
    push_exp(1'b0, 0, 8'h80);
    send_word(8'h80, 0);
    @(negedge clk);
    chk("busy_after_first_wgt", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    for (int k = 1; k < WGT; k++) begin
      push_exp(1'b0, k, 8'h80 + 8'(k));
      send_word(8'h80 + 8'(k), 0);
    end
    send_acts(400, 8'hA5, 1'b0);

    // Reset in the middle of the activation load
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // Reload after reset, stray conv_valid during the load, input held while convolving
    send_weights(8'h40);
    send_acts(ACT, 8'hC0, 1'b1);
    s_data  = 8'hC3;
    s_valid = 1'b1;
    push_exp(1'b1, 0, 8'hC3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_ready", {31'd0, s_ready}, 32'd0);
      chk("stall_no_write", {30'd0, wgt_we, act_we}, 32'd0);
      @(posedge clk); #1;
    end
    run_conv(1'b0, 1'b1);
    s_valid = 1'b0;

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("img_done_count", done_seen, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
